// File: rtl/iosys_host_if.sv
// ---------------------------------------------------------------------------
// iosys_host_if -- bus bundle between the I/O-system host and its environment.
//
// Signals:
//   cmd_valid/cmd_ready, cmd_op[3:0], cmd_arg[31:0], cmd_len[23:0]
//                          command handshake and command fields
//   pl_data[7:0], pl_valid/pl_ready
//                          payload byte stream for the payload opcodes
//   tx_data[7:0], tx_start, tx_busy
//                          byte port towards the UART transmitter
//   rx_data[7:0], rx_valid byte strobe from the UART receiver
//
// Modports:
//   master -- environment side (command source, payload source, UART)
//   slave  -- the iosys_host block itself
// ---------------------------------------------------------------------------
interface iosys_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [23:0] cmd_len;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_len,
    output pl_data, pl_valid,
    output tx_busy,
    output rx_data, rx_valid,
    input  cmd_ready, pl_ready, tx_data, tx_start
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_len,
    input  pl_data, pl_valid,
    input  tx_busy,
    input  rx_data, rx_valid,
    output cmd_ready, pl_ready, tx_data, tx_start
  );
endinterface

// File: rtl/iosys_host.sv
// ---------------------------------------------------------------------------
// iosys_host -- host side of a UART-based I/O-system link.
//
// A transmit FSM serialises commands (opcode, argument bytes, optional
// payload and terminator) to a UART transmitter; for opcodes 1 and 2 it then
// waits for the matching reply or a timeout.  An independent receive parser
// decodes joypad, core-ID and config-string messages from the UART receiver.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   bus            iosys_host_if.slave (command, payload, tx and rx byte ports)
//   core_id[7:0]   / core_id_valid      received core ID + 1-cycle strobe
//   cfg_char[7:0]  / cfg_char_valid     config-string character + strobe
//   cfg_done                            end-of-string strobe
//   joy1, joy2[15:0] / joy_update       joypad words + update strobe
//   busy                                transmit FSM not idle
//   cmd_err                             strobe: unsupported opcode consumed
//   resp_timeout                        strobe: reply wait expired
// ---------------------------------------------------------------------------
module iosys_host #(
  parameter int unsigned FREQ            = 21_477_000,
  parameter int unsigned RESP_TIMEOUT_MS = 100,
  parameter int unsigned MAX_STR         = 96
) (
  input  logic         clk,
  input  logic         reset,
  iosys_host_if.slave  bus,
  output logic [7:0]   core_id,
  output logic         core_id_valid,
  output logic [7:0]   cfg_char,
  output logic         cfg_char_valid,
  output logic         cfg_done,
  output logic [15:0]  joy1,
  output logic [15:0]  joy2,
  output logic         joy_update,
  output logic         busy,
  output logic         cmd_err,
  output logic         resp_timeout
);

  localparam int unsigned TMO_RAW    = FREQ / 1000 * RESP_TIMEOUT_MS;
  localparam int unsigned TMO_CYCLES = (TMO_RAW == 0) ? 1 : TMO_RAW;
  localparam logic [31:0] TMO_LOAD   = 32'(TMO_CYCLES);
  localparam logic [15:0] STR_LAST   = 16'(MAX_STR - 1);

  localparam logic [2:0] T_IDLE    = 3'd0;
  localparam logic [2:0] T_OP      = 3'd1;
  localparam logic [2:0] T_ARG     = 3'd2;
  localparam logic [2:0] T_PAYLOAD = 3'd3;
  localparam logic [2:0] T_TERM    = 3'd4;
  localparam logic [2:0] T_WAIT    = 3'd5;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_JOY  = 2'd1;
  localparam logic [1:0] R_ID   = 2'd2;
  localparam logic [1:0] R_STR  = 2'd3;

  // Number of argument bytes that follow the opcode byte.
  function automatic logic [2:0] arg_count(input logic [3:0] op);
    case (op)
      4'd3:    arg_count = 3'd4;
      4'd4:    arg_count = 3'd2;
      4'd6:    arg_count = 3'd1;
      4'd7:    arg_count = 3'd3;
      4'd8:    arg_count = 3'd1;
      4'd9:    arg_count = 3'd4;
      default: arg_count = 3'd0;
    endcase
  endfunction

  // Argument byte number idx for the given opcode.
  function automatic logic [7:0] arg_byte(input logic [3:0] op, input logic [31:0] arg,
                                          input logic [23:0] len, input logic [2:0] idx);
    case (op)
      4'd3: begin
        case (idx)
          3'd0:    arg_byte = arg[31:24];
          3'd1:    arg_byte = arg[23:16];
          3'd2:    arg_byte = arg[15:8];
          default: arg_byte = arg[7:0];
        endcase
      end
      4'd4:    arg_byte = (idx == 3'd0) ? arg[15:8] : arg[7:0];
      4'd6:    arg_byte = arg[7:0];
      4'd7: begin
        case (idx)
          3'd0:    arg_byte = len[23:16];
          3'd1:    arg_byte = len[15:8];
          default: arg_byte = len[7:0];
        endcase
      end
      4'd8:    arg_byte = {7'b0000000, arg[0]};
      4'd9: begin
        case (idx)
          3'd0:    arg_byte = arg[7:0];
          3'd1:    arg_byte = arg[15:8];
          3'd2:    arg_byte = arg[23:16];
          default: arg_byte = arg[31:24];
        endcase
      end
      default: arg_byte = 8'h00;
    endcase
  endfunction

  logic [2:0]  state_r;
  logic [3:0]  op_r;
  logic [31:0] arg_r;
  logic [23:0] len_r;
  logic [2:0]  idx_r;
  logic [31:0] tmo_r;
  logic        ready_en_r;
  logic [7:0]  tx_data_r;
  logic        tx_start_r;
  logic        cmd_err_r;
  logic        resp_timeout_r;
  logic        can_emit_s;
  logic        pl_ready_s;
  logic        cmd_ready_s;
  logic [2:0]  post_hdr_s;

  logic [1:0]  rstate_r;
  logic [1:0]  jcnt_r;
  logic [23:0] jbuf_r;
  logic [15:0] str_cnt_r;
  logic [15:0] joy1_r;
  logic [15:0] joy2_r;
  logic        joy_update_r;
  logic [7:0]  core_id_r;
  logic        core_id_valid_r;
  logic [7:0]  cfg_char_r;
  logic        cfg_char_valid_r;
  logic        cfg_done_r;

  // A byte may go out only when the UART is free and no byte left last cycle.
  assign can_emit_s  = ~bus.tx_busy & ~tx_start_r;
  assign pl_ready_s  = (state_r == T_PAYLOAD) & can_emit_s;
  // ready_en_r keeps cmd_ready low while reset is held.
  assign cmd_ready_s = (state_r == T_IDLE) & ready_en_r;

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.pl_ready  = pl_ready_s;
  assign bus.tx_data   = tx_data_r;
  assign bus.tx_start  = tx_start_r;
  assign busy          = (state_r != T_IDLE);
  assign cmd_err       = cmd_err_r;
  assign resp_timeout  = resp_timeout_r;

  assign joy1           = joy1_r;
  assign joy2           = joy2_r;
  assign joy_update     = joy_update_r;
  assign core_id        = core_id_r;
  assign core_id_valid  = core_id_valid_r;
  assign cfg_char       = cfg_char_r;
  assign cfg_char_valid = cfg_char_valid_r;
  assign cfg_done       = cfg_done_r;

  // Where the TX FSM goes once the opcode and argument bytes are out.
  always_comb begin
    post_hdr_s = T_IDLE;
    if (op_r == 4'd5) begin
      if (len_r == 24'd0) begin
        post_hdr_s = T_TERM;
      end else begin
        post_hdr_s = T_PAYLOAD;
      end
    end else if (op_r == 4'd7) begin
      if (len_r == 24'd0) begin
        post_hdr_s = T_IDLE;
      end else begin
        post_hdr_s = T_PAYLOAD;
      end
    end else if ((op_r == 4'd1) || (op_r == 4'd2)) begin
      post_hdr_s = T_WAIT;
    end else begin
      post_hdr_s = T_IDLE;
    end
  end

  // TX FSM: command acceptance, byte emission and reply wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= T_IDLE;
      op_r           <= 4'd0;
      arg_r          <= 32'd0;
      len_r          <= 24'd0;
      idx_r          <= 3'd0;
      tmo_r          <= 32'd0;
      ready_en_r     <= 1'b0;
      tx_data_r      <= 8'h00;
      tx_start_r     <= 1'b0;
      cmd_err_r      <= 1'b0;
      resp_timeout_r <= 1'b0;
    end else begin
      ready_en_r     <= 1'b1;
      tx_start_r     <= 1'b0;
      cmd_err_r      <= 1'b0;
      resp_timeout_r <= 1'b0;
      case (state_r)
        T_IDLE: begin
          if (bus.cmd_valid && cmd_ready_s) begin
            if ((bus.cmd_op != 4'd0) && (bus.cmd_op <= 4'd9)) begin
              op_r    <= bus.cmd_op;
              arg_r   <= bus.cmd_arg;
              len_r   <= bus.cmd_len;
              idx_r   <= 3'd0;
              state_r <= T_OP;
            end else begin
              cmd_err_r <= 1'b1;
            end
          end
        end
        T_OP: begin
          if (can_emit_s) begin
            tx_data_r  <= {4'h0, op_r};
            tx_start_r <= 1'b1;
            if (arg_count(op_r) != 3'd0) begin
              state_r <= T_ARG;
            end else begin
              state_r <= post_hdr_s;
              if (post_hdr_s == T_WAIT) begin
                tmo_r <= TMO_LOAD;
              end
            end
          end
        end
        T_ARG: begin
          if (can_emit_s) begin
            tx_data_r  <= arg_byte(op_r, arg_r, len_r, idx_r);
            tx_start_r <= 1'b1;
            if (idx_r == (arg_count(op_r) - 3'd1)) begin
              state_r <= post_hdr_s;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        T_PAYLOAD: begin
          // Payload bytes pass through unchanged, including 0x00.
          if (pl_ready_s && bus.pl_valid) begin
            tx_data_r  <= bus.pl_data;
            tx_start_r <= 1'b1;
            len_r      <= len_r - 24'd1;
            if (len_r == 24'd1) begin
              state_r <= (op_r == 4'd5) ? T_TERM : T_IDLE;
            end
          end
        end
        T_TERM: begin
          if (can_emit_s) begin
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b1;
            state_r    <= T_IDLE;
          end
        end
        T_WAIT: begin
          if (((op_r == 4'd1) && core_id_valid_r) || ((op_r == 4'd2) && cfg_done_r)) begin
            state_r <= T_IDLE;
          end else if (tmo_r <= 32'd1) begin
            resp_timeout_r <= 1'b1;
            tmo_r          <= 32'd0;
            state_r        <= T_IDLE;
          end else begin
            tmo_r <= tmo_r - 32'd1;
          end
        end
        default: state_r <= T_IDLE;
      endcase
    end
  end

  // RX parser: header decode and message collection, independent of TX.
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate_r         <= R_IDLE;
      jcnt_r           <= 2'd0;
      jbuf_r           <= 24'd0;
      str_cnt_r        <= 16'd0;
      joy1_r           <= 16'hFFFF;
      joy2_r           <= 16'hFFFF;
      joy_update_r     <= 1'b0;
      core_id_r        <= 8'h00;
      core_id_valid_r  <= 1'b0;
      cfg_char_r       <= 8'h00;
      cfg_char_valid_r <= 1'b0;
      cfg_done_r       <= 1'b0;
    end else begin
      joy_update_r     <= 1'b0;
      core_id_valid_r  <= 1'b0;
      cfg_char_valid_r <= 1'b0;
      cfg_done_r       <= 1'b0;
      if (bus.rx_valid) begin
        case (rstate_r)
          R_IDLE: begin
            case (bus.rx_data)
              8'h01: begin
                rstate_r <= R_JOY;
                jcnt_r   <= 2'd0;
              end
              8'h11:   rstate_r <= R_ID;
              8'h22: begin
                rstate_r  <= R_STR;
                str_cnt_r <= 16'd0;
              end
              default: rstate_r <= R_IDLE;
            endcase
          end
          R_JOY: begin
            // Both words update together on the 4th byte.
            if (jcnt_r == 2'd3) begin
              joy1_r       <= jbuf_r[15:0];
              joy2_r       <= {bus.rx_data, jbuf_r[23:16]};
              joy_update_r <= 1'b1;
              rstate_r     <= R_IDLE;
            end else begin
              jbuf_r[{jcnt_r, 3'b000} +: 8] <= bus.rx_data;
              jcnt_r <= jcnt_r + 2'd1;
            end
          end
          R_ID: begin
            core_id_r       <= bus.rx_data;
            core_id_valid_r <= 1'b1;
            rstate_r        <= R_IDLE;
          end
          R_STR: begin
            if (bus.rx_data == 8'h00) begin
              cfg_done_r <= 1'b1;
              rstate_r   <= R_IDLE;
            end else begin
              cfg_char_r       <= bus.rx_data;
              cfg_char_valid_r <= 1'b1;
              if (str_cnt_r == STR_LAST) begin
                cfg_done_r <= 1'b1;
                rstate_r   <= R_IDLE;
              end else begin
                str_cnt_r <= str_cnt_r + 16'd1;
              end
            end
          end
          default: rstate_r <= R_IDLE;
        endcase
      end
    end
  end

endmodule
